// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning the architectural HI/LO registers.
// Multiplies complete after a fixed latency; divides run a 32-step radix-2
// restoring loop followed by one sign fix-up edge. Flush aborts in-flight ops.
module mdu_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    localparam logic [5:0] MUL_LAT_C = 6'(MUL_LAT);
    localparam logic [5:0] DIV_FIX   = 6'd32;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] opa;        // multiplicand, or dividend shifting into quotient
    logic [31:0] opb;        // multiplier, or divisor magnitude
    logic [31:0] rem;        // partial remainder magnitude
    logic        op_signed;  // signed multiply
    logic        q_neg;      // negate quotient at fix-up
    logic        r_neg;      // negate remainder at fix-up

    logic        accept;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        div_zero;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    // Acceptance, product and one restoring-division step from latched operands
    always_comb begin
        accept   = req_valid & req_ready & ~flush;
        ext_a    = {{32{op_signed & opa[31]}}, opa};
        ext_b    = {{32{op_signed & opb[31]}}, opb};
        prod     = ext_a * ext_b;
        shifted  = {rem, opa[31]};
        diff     = shifted - {1'b0, opb};
        div_zero = (opb == '0);
    end

    // Sequencer FSM with registered handshake outputs and HI/LO updates
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            opa       <= '0;
            opb       <= '0;
            rem       <= '0;
            op_signed <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_div | op_divu) begin
                            state     <= S_DIV;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                            cnt       <= '0;
                            rem       <= '0;
                            opa       <= op_div ? abs32(src1) : src1;
                            opb       <= op_div ? abs32(src2) : src2;
                            q_neg     <= op_div & (src1[31] ^ src2[31]);
                            r_neg     <= op_div & src1[31];
                        end else if (op_mult | op_multu) begin
                            state     <= S_MUL;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                            cnt       <= 6'd1;
                            opa       <= src1;
                            opb       <= src2;
                            op_signed <= op_mult;
                        end else if (op_mthi) begin
                            hi <= src1;
                        end else if (op_mtlo) begin
                            lo <= src1;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else if (cnt == MUL_LAT_C) begin
                        {hi, lo}  <= prod;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else if (cnt == DIV_FIX) begin
                        // Divisor 0 leaves quotient all-ones and remainder = |dividend|;
                        // forcing lo keeps the signed case from negating the all-ones.
                        lo        <= div_zero ? '1 : (q_neg ? (32'd0 - opa) : opa);
                        hi        <= r_neg ? (32'd0 - rem) : rem;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        rem <= diff[32] ? shifted[31:0] : diff[31:0];
                        opa <= {opa[30:0], ~diff[32]};
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO and done cycle,
// a negedge monitor pops and compares whenever done is presented.
module tb_mdu_ctrl;

    localparam int unsigned ML = 2;
    localparam int unsigned DL = 33;

    localparam int OP_NONE  = 0;
    localparam int OP_MULT  = 1;
    localparam int OP_MULTU = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_DIVU  = 4;
    localparam int OP_MTHI  = 5;
    localparam int OP_MTLO  = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        op_mult = 1'b0;
    logic        op_multu = 1'b0;
    logic        op_div = 1'b0;
    logic        op_divu = 1'b0;
    logic        op_mthi = 1'b0;
    logic        op_mtlo = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mdu_ctrl #(.MUL_LAT(ML)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_mult   (op_mult),
        .op_multu  (op_multu),
        .op_div    (op_div),
        .op_divu   (op_divu),
        .op_mthi   (op_mthi),
        .op_mtlo   (op_mtlo),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request for one edge; returns #1 after the accepting edge.
    task automatic send(input int op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        op_mult   = (op == OP_MULT);
        op_multu  = (op == OP_MULTU);
        op_div    = (op == OP_DIV);
        op_divu   = (op == OP_DIVU);
        op_mthi   = (op == OP_MTHI);
        op_mtlo   = (op == OP_MTLO);
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_mult   = 1'b0;
        op_multu  = 1'b0;
        op_div    = 1'b0;
        op_divu   = 1'b0;
        op_mthi   = 1'b0;
        op_mtlo   = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int unsigned lat);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.cyc = cyc + int'(lat);
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Monitor: every done pulse must match the next scoreboard entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;

        // Reset mid-DIV
        send(OP_MTHI, 32'h55, 32'h0);
        chk("mthi_pre", hi, 32'h55);
        send(OP_DIVU, 32'd100, 32'd7);
        step(5);
        chk("div_busy", {31'd0, busy}, 32'd1);
        chk("div_not_ready", {31'd0, req_ready}, 32'd0);
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Multiplies
        send(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, ML);
        chk("mul_busy", {31'd0, busy}, 32'd1);
        chk("mul_not_ready", {31'd0, req_ready}, 32'd0);
        wait_ready();
        send(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        push_exp(32'h0000_0002, 32'hFFFF_FFFA, ML);
        wait_ready();

        // Divides
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, DL);
        step(20);
        chk("div_busy_mid", {31'd0, busy}, 32'd1);
        wait_ready();
        send(OP_DIVU, 32'd100, 32'd7);
        push_exp(32'd2, 32'd14, DL);
        wait_ready();
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        push_exp(32'h0, 32'h8000_0000, DL);
        wait_ready();
        send(OP_DIVU, 32'd5, 32'd0);
        push_exp(32'd5, 32'hFFFF_FFFF, DL);
        wait_ready();
        send(OP_DIV, 32'hFFFF_FFF7, 32'd0);
        push_exp(32'hFFFF_FFF7, 32'hFFFF_FFFF, DL);
        wait_ready();
        send(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        push_exp(32'd1, 32'hFFFF_FFFD, DL);
        wait_ready();

        // Flush mid-DIV
        send(OP_MTHI, 32'h11, 32'h0);
        chk("mthi_11", hi, 32'h11);
        send(OP_MTLO, 32'h22, 32'h0);
        chk("mtlo_22", lo, 32'h22);
        send(OP_DIV, 32'd1000, 32'd3);
        step(10);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("flush_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        step(40);
        chk("flush_hi", hi, 32'h11);
        chk("flush_lo", lo, 32'h22);

        // Flush while IDLE blocks acceptance
        flush = 1'b1;
        send(OP_MTHI, 32'h99, 32'h0);
        chk("idle_flush_hi", hi, 32'h11);
        send(OP_DIV, 32'd9, 32'd3);
        chk("idle_flush_busy", {31'd0, busy}, 32'd0);
        flush = 1'b0;

        // Flush on the final MUL edge
        send(OP_MULT, 32'd7, 32'd9);
        step(1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("mulflush_hi", hi, 32'h11);
        chk("mulflush_lo", lo, 32'h22);
        chk("mulflush_busy", {31'd0, busy}, 32'd0);
        step(5);

        // MTHI then MTLO on consecutive edges
        send(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);
        send(OP_MTLO, 32'h1234_5678, 32'h0);
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi", hi, 32'hDEAD_BEEF);
        chk("mtlo_done", {31'd0, done}, 32'd0);

        // MULT accepted on the done cycle of a DIV
        send(OP_DIVU, 32'd100, 32'd7);
        push_exp(32'd2, 32'd14, DL);
        wait_done();
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        send(OP_MULT, 32'd3, 32'd5);
        push_exp(32'd0, 32'd15, ML);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_ready();

        step(4);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
